// File: rtl/ring_token_sched.sv
// ring_token_sched: single-token ring arbiter with a hold limit,
// timeout-driven token regeneration, starvation flag and round pulse.
module ring_token_sched #(
  parameter int N          = 4,
  parameter int IDW        = 2,
  parameter int HOLD_MAX   = 3,
  parameter int TIMEOUT    = 8,
  parameter int STARVE_MAX = 24
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   rel,
  input  logic           loss,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] token_pos,
  output logic           token_valid,
  output logic           regen,
  output logic           error,
  output logic           objective
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_AT,
    S_HOLD,
    S_PASS,
    S_LOST
  } state_t;

  state_t               state_q;
  state_t               state_n;
  logic [IDW-1:0]       pos_n;
  logic [HW-1:0]        hold_q;
  logic [HW-1:0]        hold_n;
  logic [LW-1:0]        lost_q;
  logic [LW-1:0]        lost_n;
  logic                 regen_n;
  logic                 cur_req;
  logic                 cur_rel;
  logic [N-1:0]         grant_n;
  logic [N-1:0]         served_q;
  logic [N-1:0]         served_n;
  logic [N-1:0]         served_set;
  logic                 obj_n;
  logic                 starve;
  logic [N-1:0][SW-1:0] wait_q;
  logic [N-1:0][SW-1:0] wait_n;

  assign cur_req = req[token_pos];
  assign cur_rel = rel[token_pos];

  always_comb begin
    state_n = state_q;
    pos_n   = token_pos;
    hold_n  = hold_q;
    lost_n  = lost_q;
    regen_n = 1'b0;
    unique case (state_q)
      S_INIT: begin
        state_n = S_AT;
        pos_n   = '0;
      end
      S_AT: begin
        if (cur_req) begin
          state_n = S_HOLD;
          hold_n  = '0;
        end else begin
          state_n = S_PASS;
        end
      end
      S_HOLD: begin
        hold_n = hold_q + 1'b1;
        if (cur_rel || !cur_req ||
            hold_q == HW'(HOLD_MAX - 1)) begin
          state_n = S_PASS;
          hold_n  = '0;
        end
      end
      S_PASS: begin
        if (loss) begin
          state_n = S_LOST;
          lost_n  = '0;
        end else begin
          state_n = S_AT;
          pos_n   = (token_pos == IDW'(N - 1)) ?
                    '0 : token_pos + 1'b1;
        end
      end
      S_LOST: begin
        lost_n = lost_q + 1'b1;
        if (lost_q == LW'(TIMEOUT - 1)) begin
          state_n = S_AT;
          pos_n   = '0;
          lost_n  = '0;
          regen_n = 1'b1;
        end
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  // a node counts as served on the cycle its grant rises
  always_comb begin
    grant_n = '0;
    if (state_n == S_HOLD) grant_n[pos_n] = 1'b1;
    served_set = served_q | (grant_n & ~grant);
    obj_n      = &served_set;
    served_n   = obj_n ? '0 : served_set;
  end

  always_comb begin
    wait_n = wait_q;
    starve = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || grant[i]) begin
        wait_n[i] = '0;
      end else if (wait_q[i] != SW'(STARVE_MAX)) begin
        wait_n[i] = wait_q[i] + 1'b1;
      end
      if (wait_n[i] == SW'(STARVE_MAX)) starve = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      token_pos   <= '0;
      hold_q      <= '0;
      lost_q      <= '0;
      grant       <= '0;
      token_valid <= 1'b0;
      regen       <= 1'b0;
      error       <= 1'b0;
      objective   <= 1'b0;
      served_q    <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_n;
      token_pos   <= pos_n;
      hold_q      <= hold_n;
      lost_q      <= lost_n;
      grant       <= grant_n;
      token_valid <= (state_n == S_AT) ||
                     (state_n == S_HOLD);
      regen       <= regen_n;
      error       <= error | starve;
      objective   <= obj_n;
      served_q    <= served_n;
      wait_q      <= wait_n;
    end
  end

endmodule

// File: tb/tb_ring_token_sched.sv
// tb_ring_token_sched: directed scenarios compared every cycle with
// a behavioural ring model, plus hand-computed spot checks.
module tb_ring_token_sched;

  localparam int N          = 4;
  localparam int HOLD_MAX   = 3;
  localparam int TIMEOUT    = 8;
  localparam int STARVE_MAX = 24;

  localparam int MD_START = 0;
  localparam int MD_AT    = 1;
  localparam int MD_HOLD  = 2;
  localparam int MD_PASS  = 3;
  localparam int MD_LOST  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic       loss = 1'b0;
  logic [3:0] grant;
  logic [1:0] token_pos;
  logic       token_valid;
  logic       regen;
  logic       error;
  logic       objective;

  ring_token_sched #(
    .N(N), .IDW(2), .HOLD_MAX(HOLD_MAX),
    .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .rel(rel),
    .loss(loss),
    .grant(grant),
    .token_pos(token_pos),
    .token_valid(token_valid),
    .regen(regen),
    .error(error),
    .objective(objective)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: mode, token position, grant length, LOST cycles left
  int         m_mode;
  int         m_pos;
  int         m_gl;
  int         m_left;
  int         m_wait [N];
  logic [3:0] m_served;
  logic [3:0] e_grant;
  logic       e_valid;
  logic       e_regen;
  logic       e_err;
  logic       e_obj;
  int         e_pos;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = MD_START;
    m_pos    = 0;
    m_gl     = 0;
    m_left   = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_served = '0;
    e_grant  = '0;
    e_valid  = 1'b0;
    e_regen  = 1'b0;
    e_err    = 1'b0;
    e_obj    = 1'b0;
    e_pos    = 0;
  endtask

  task automatic model_step();
    logic [3:0] ng;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i] || e_grant[i]) m_wait[i] = 0;
      else if (m_wait[i] < STARVE_MAX) m_wait[i]++;
      if (m_wait[i] >= STARVE_MAX) e_err = 1'b1;
    end
    e_regen = 1'b0;
    e_obj   = 1'b0;
    case (m_mode)
      MD_START: begin
        m_mode = MD_AT;
        m_pos  = 0;
      end
      MD_AT: begin
        if (req[m_pos]) begin
          m_mode = MD_HOLD;
          m_gl   = 1;
        end else begin
          m_mode = MD_PASS;
        end
      end
      MD_HOLD: begin
        if (rel[m_pos] || !req[m_pos] || m_gl >= HOLD_MAX)
          m_mode = MD_PASS;
        else
          m_gl++;
      end
      MD_PASS: begin
        if (loss) begin
          m_mode = MD_LOST;
          m_left = TIMEOUT;
        end else begin
          m_mode = MD_AT;
          m_pos  = (m_pos + 1) % N;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = MD_AT;
          m_pos   = 0;
          e_regen = 1'b1;
        end
      end
    endcase
    ng = (m_mode == MD_HOLD) ? 4'(1 << m_pos) : 4'b0;
    if ((ng & ~e_grant) != 4'b0) begin
      m_served = m_served | ng;
      if (m_served == 4'b1111) begin
        e_obj    = 1'b1;
        m_served = '0;
      end
    end
    e_grant = ng;
    e_valid = (m_mode == MD_AT) || (m_mode == MD_HOLD);
    e_pos   = m_pos;
  endtask

  task automatic check(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ".pos"}, 32'(token_pos), 32'(e_pos));
    chk({tag, ".valid"}, 32'(token_valid), 32'(e_valid));
    chk({tag, ".regen"}, 32'(regen), 32'(e_regen));
    chk({tag, ".error"}, 32'(error), 32'(e_err));
    chk({tag, ".obj"}, 32'(objective), 32'(e_obj));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    rel     = '0;
    loss    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst");
    reset_n = 1'b1;
  endtask

  logic [8:0] vb;
  logic [3:0] gor;
  int         p7, p9, gcnt, first, p10, v10;
  int         inval, rcnt, rcyc, p11;
  int         glen [4];
  int         ocnt, ocyc, ecyc;

  initial begin
    // 1: idle circulation
    do_reset();
    vb  = '0;
    gor = '0;
    p7  = -1;
    p9  = -1;
    for (int k = 1; k <= 9; k++) begin
      cyc("t1");
      vb[k-1] = token_valid;
      gor     = gor | grant;
      if (k == 7) p7 = int'(token_pos);
      if (k == 9) p9 = int'(token_pos);
    end
    chk("t1.valid_pattern", 32'(vb), 32'h155);
    chk("t1.pos_c7", 32'(p7), 32'd3);
    chk("t1.pos_c9", 32'(p9), 32'd0);
    chk("t1.no_grant", 32'(gor), 32'd0);

    // 2: hold limit on node 2
    do_reset();
    req   = 4'b0100;
    gcnt  = 0;
    first = 0;
    p10   = -1;
    v10   = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc("t2");
      if (grant == 4'b0100) begin
        gcnt++;
        if (first == 0) first = k;
      end
      if (k == 10) begin
        p10 = int'(token_pos);
        v10 = int'(token_valid);
      end
    end
    chk("t2.grant_len", 32'(gcnt), 32'd3);
    chk("t2.grant_first", 32'(first), 32'd6);
    chk("t2.pos_c10", 32'(p10), 32'd3);
    chk("t2.valid_c10", 32'(v10), 32'd1);

    // 3: token lost in first PASS, loss also high in AT
    do_reset();
    inval = 0;
    rcnt  = 0;
    rcyc  = 0;
    p11   = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc("t3");
      if (k >= 2 && k <= 11 && !token_valid) inval++;
      if (regen) begin
        rcnt++;
        rcyc = k;
      end
      if (k == 11) p11 = int'(token_pos);
      loss = (k <= 2);
    end
    chk("t3.invalid_len", 32'(inval), 32'd9);
    chk("t3.regen_cnt", 32'(rcnt), 32'd1);
    chk("t3.regen_cyc", 32'(rcyc), 32'd11);
    chk("t3.pos_c11", 32'(p11), 32'd0);

    // 4: everyone requests, early release
    do_reset();
    req  = 4'b1111;
    ocnt = 0;
    ocyc = 0;
    for (int i = 0; i < 4; i++) glen[i] = 0;
    for (int k = 1; k <= 18; k++) begin
      cyc("t4");
      if (k <= 16)
        for (int i = 0; i < 4; i++)
          if (grant[i]) glen[i]++;
      if (objective) begin
        ocnt++;
        ocyc = k;
      end
      case (k)
        3:       rel = 4'b0001;
        7:       rel = 4'b0010;
        11:      rel = 4'b0100;
        15:      rel = 4'b1000;
        default: rel = 4'b0000;
      endcase
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4.glen%0d", i),
          32'(glen[i]), 32'd2);
    chk("t4.obj_cnt", 32'(ocnt), 32'd1);
    chk("t4.obj_cyc", 32'(ocyc), 32'd14);
    rel = '0;

    // 5: starvation of node 1
    do_reset();
    req  = 4'b0010;
    loss = 1'b1;
    ecyc = 0;
    gor  = '0;
    for (int k = 1; k <= 33; k++) begin
      cyc("t5");
      gor = gor | grant;
      if (error && ecyc == 0) ecyc = k;
      if (k == 30) req = '0;
    end
    chk("t5.err_cyc", 32'(ecyc), 32'd24);
    chk("t5.err_sticky", 32'(error), 32'd1);
    chk("t5.no_grant", 32'(gor), 32'd0);
    loss = 1'b0;

    // 6: asynchronous reset in the middle of a grant
    do_reset();
    req = 4'b0001;
    cyc("t6");
    cyc("t6");
    chk("t6.grant_pre", 32'(grant), 32'h1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6.async_grant", 32'(grant), 32'h0);
    chk("t6.async_valid", 32'(token_valid), 32'h0);
    @(negedge clk);
    check("t6.rst");
    reset_n = 1'b1;
    cyc("t6r");
    chk("t6.restart_valid", 32'(token_valid), 32'h1);
    cyc("t6r");
    chk("t6.regrant", 32'(grant), 32'h1);
    chk("t6.error_clear", 32'(error), 32'h0);
    req = '0;
    cyc("t6r");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
